ddr3_rd_unpack: RTL and testbench

Read-side width converter for the DDR3 path. It buffers 256-bit read-data beats returned by the DDR3 controller and emits them as a stream of 32-bit words over a valid/ready handshake. It is the counterpart of the 32-to-256 write FIFO and sits between the DDR3 read-data port and the 32-bit user/bus side. It provides an almost-full flag so the read-request generator can throttle outstanding reads, because DDR3 read data cannot be back-pressured.

---
 rtl/ddr3_rd_pkg.sv | 21 ++
 rtl/ddr3_rd_beat_ram.sv | 19 +
 rtl/ddr3_rd_unpack.sv | 83 ++++++++
 tb/tb_ddr3_rd_unpack.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ddr3_rd_pkg.sv
// ddr3_rd_pkg: shared widths and elaboration-time helpers for the DDR3 read/write width converters.
package ddr3_rd_pkg;
  localparam int DEF_IN_WIDTH  = 256;
  localparam int DEF_OUT_WIDTH = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int words_per_beat(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
  function automatic int ptr_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
  function automatic int cnt_width(input int n);
    return clog2(n) + 1;
  endfunction
endpackage

// File: rtl/ddr3_rd_beat_ram.sv
// ddr3_rd_beat_ram: DEPTH x W simple dual-port beat storage, registered write, asynchronous read (distributed RAM).
module ddr3_rd_beat_ram #(
  parameter int W     = 256,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ddr3_rd_unpack.sv
// ddr3_rd_unpack: buffers wide DDR3 read beats and streams them out as narrow words over valid/ready.
// Define DDR3_RD_UNPACK_MSW_FIRST_EN to emit the most-significant word of each beat first.
module ddr3_rd_unpack
  import ddr3_rd_pkg::*;
#(
  parameter int IN_WIDTH        = DEF_IN_WIDTH,
  parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
  parameter int DEPTH           = 8,
  parameter int ALMOST_FULL_NUM = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  almost_full,
  output logic [clog2(DEPTH):0] level,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf_err
);
  localparam int WPB = words_per_beat(IN_WIDTH, OUT_WIDTH);
  localparam int PW  = ptr_width(DEPTH);
  localparam int CW  = cnt_width(DEPTH);
  localparam int WW  = ptr_width(WPB);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] word_idx_q, word_idx_d, sel;
  logic ovf_q, ovf_d;
  logic push, fire, last, pop;
  logic [WPB-1:0][OUT_WIDTH-1:0] beat;
  ddr3_rd_beat_ram #(
    .W     (IN_WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (beat)
  );
  assign in_ready    = count_q != CW'(DEPTH);
  assign almost_full = count_q >= CW'(ALMOST_FULL_NUM);
  assign level       = count_q;
  assign out_valid   = count_q != '0;
  assign ovf_err     = ovf_q;
  always_comb begin
`ifdef DDR3_RD_UNPACK_MSW_FIRST_EN
    sel = WW'(WPB - 1) - word_idx_q;
`else
    sel = word_idx_q;
`endif
    out_data   = out_valid ? beat[sel] : '0;
    push       = in_valid && in_ready;
    fire       = out_valid && out_ready;
    last       = word_idx_q == WW'(WPB - 1);
    pop        = fire && last;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    word_idx_d = fire ? (last ? '0 : word_idx_q + 1'b1) : word_idx_q;
    count_d    = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    ovf_d      = ovf_q || (in_valid && !in_ready);
  end
  // Stored beats are left in place on reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_ddr3_rd_unpack.sv
// tb_ddr3_rd_unpack: randomized self-checking bench against a word-queue model of the unpacker.
module tb_ddr3_rd_unpack;
  localparam int IW = 256, OW = 32, D = 8, AF = 6, WPB = IW / OW;
  logic clk = 1'b0, rst = 1'b1;
  logic [IW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_ready, almost_full, out_valid, out_ready = 1'b0, ovf_err;
  logic [3:0] level;
  logic [OW-1:0] out_data;
  logic [OW-1:0] q[$];
  bit m_ovf;
  int max_lvl;
  int tests, fails;
  always #5 clk = ~clk;
  ddr3_rd_unpack #(
    .IN_WIDTH        (IW),
    .OUT_WIDTH       (OW),
    .DEPTH           (D),
    .ALMOST_FULL_NUM (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .almost_full (almost_full),
    .level       (level),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ovf_err     (ovf_err)
  );
  function automatic int m_level();
    return (q.size() + WPB - 1) / WPB;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit v, input logic [IW-1:0] d, input bit r);
    bit rdy, ov;
    in_valid = v;
    in_data = d;
    out_ready = r;
    @(negedge clk);
    chk("level", 32'(level), 32'(m_level()));
    chk("in_ready", 32'(in_ready), 32'(m_level() != D));
    chk("almost_full", 32'(almost_full), 32'(m_level() >= AF));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data", out_data, q.size() != 0 ? q[0] : 32'h0);
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (m_level() > max_lvl) max_lvl = m_level();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      rdy = m_level() != D;
      ov = q.size() != 0;
      if (ov && r) void'(q.pop_front());
      if (v && rdy) begin
        for (int k = 0; k < WPB; k++)
`ifdef DDR3_RD_UNPACK_MSW_FIRST_EN
          q.push_back(d[(WPB-1-k)*OW +: OW]);
`else
          q.push_back(d[k*OW +: OW]);
`endif
      end else if (v) m_ovf = 1'b1;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);
  endtask
  function automatic logic [IW-1:0] rnd_beat();
    logic [IW-1:0] b;
    for (int k = 0; k < WPB; k++) b[k*OW +: OW] = $urandom;
    return b;
  endfunction
  initial begin
    logic [IW-1:0] ramp;
    tests = 0;
    fails = 0;
    m_ovf = 1'b0;
    for (int k = 0; k < WPB; k++) ramp[k*OW +: OW] = 32'(k);
    do_reset();
    cyc(1'b1, ramp, 1'b1);
    repeat (WPB + 2) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, ramp, 1'b0);
    for (int i = 0; i < 3 * WPB + 4; i++) cyc(1'b0, '0, (i % 3) == 0);
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < D + 1; i++) cyc(1'b1, rnd_beat(), 1'b0);
    chk("ovf_after_fill", 32'(ovf_err), 32'd1);
    repeat (D * WPB + 3) cyc(1'b0, '0, 1'b1);
    do_reset();
    max_lvl = 0;
    for (int i = 0; i < 20 * WPB + 4; i++) cyc((i % WPB) == 0 && i < 20 * WPB, rnd_beat(), 1'b1);
    chk("stream_max_level", 32'(max_lvl <= 2), 32'd1);
    chk("stream_ovf", 32'(ovf_err), 32'd0);
    do_reset();
    cyc(1'b1, rnd_beat(), 1'b0);
    cyc(1'b1, rnd_beat(), 1'b0);
    repeat (WPB + 3) cyc(1'b0, '0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);
    chk("rst_mid_level", 32'(level), 32'd0);
    cyc(1'b1, ramp, 1'b1);
    repeat (WPB + 1) cyc(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 600; i++) cyc(($urandom % 3) == 0, rnd_beat(), ($urandom % 4) != 0);
    for (int i = 0; i < 300; i++) cyc(($urandom % 2) == 0, rnd_beat(), ($urandom % 5) == 0);
    repeat (D * WPB + 2) cyc(1'b0, '0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
